// File: rtl/encap_mem_pio_arb.sv
// PIO/lookup arbiter in front of one single-port, 1-cycle-latency encap lookup RAM.
// Optional even-parity storage and checking is enabled by defining ENCAP_MEM_PARITY_EN.
module encap_mem_pio_arb #(
  parameter int unsigned ADDR_NBITS = 10,
  parameter int unsigned DATA_NBITS = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_div,
  input  logic                  reg_ms,
  input  logic                  reg_rd,
  input  logic                  reg_wr,
  input  logic [DATA_NBITS-1:0] reg_addr,
  input  logic [DATA_NBITS-1:0] reg_din,
  output logic                  mem_ack,
  output logic [DATA_NBITS-1:0] mem_rdata,
  input  logic                  lookup_req,
  input  logic [ADDR_NBITS-1:0] lookup_addr,
  output logic                  lookup_ready,
  output logic                  lookup_rvalid,
  output logic [DATA_NBITS-1:0] lookup_rdata,
  output logic                  ram_en,
  output logic                  ram_wr,
  output logic [ADDR_NBITS-1:0] ram_addr,
`ifdef ENCAP_MEM_PARITY_EN
  output logic [DATA_NBITS:0]   ram_wdata,
  input  logic [DATA_NBITS:0]   ram_rdata,
  output logic                  lookup_perr,
  output logic                  parity_err
`else
  output logic [DATA_NBITS-1:0] ram_wdata,
  input  logic [DATA_NBITS-1:0] ram_rdata
`endif
);

  typedef enum logic [1:0] {StIdle, StWait, StRd, StAck} state_e;

  localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

  state_e                r_state, w_state_next;
  logic [7:0]            r_starve_cnt, w_starve_next;
  logic                  r_is_rd;
  logic [ADDR_NBITS-1:0] r_addr;
  logic [DATA_NBITS-1:0] r_wdata;
  logic [DATA_NBITS-1:0] r_mem_rdata;
  logic                  r_lookup_rvalid;
  logic                  w_pio_grant;
  logic                  w_pio_go;
  logic                  w_lookup_acc;
  logic                  w_pio_start;
  logic                  w_unused_addr;

  assign w_unused_addr = ^reg_addr[DATA_NBITS-1:ADDR_NBITS];

  assign w_pio_start  = reg_ms & (reg_rd | reg_wr);
  assign w_pio_grant  = ~lookup_req | (r_starve_cnt == StarveMax);
  assign lookup_ready = ~((r_state == StWait) & w_pio_grant);
  // A grant coinciding with reset is dropped so an aborted write never reaches the RAM.
  assign w_pio_go     = (r_state == StWait) & w_pio_grant & ~rst;
  assign w_lookup_acc = lookup_req & lookup_ready;

  assign ram_en   = w_pio_go | w_lookup_acc;
  assign ram_wr   = w_pio_go & ~r_is_rd;
  assign ram_addr = w_pio_go ? r_addr : lookup_addr;
`ifdef ENCAP_MEM_PARITY_EN
  assign ram_wdata = {^r_wdata, r_wdata};
`else
  assign ram_wdata = r_wdata;
`endif

  assign mem_ack       = (r_state == StAck);
  assign mem_rdata     = r_mem_rdata;
  assign lookup_rvalid = r_lookup_rvalid;
  assign lookup_rdata  = ram_rdata[DATA_NBITS-1:0];

  always_comb begin
    w_state_next  = r_state;
    w_starve_next = r_starve_cnt;
    unique case (r_state)
      StIdle: if (w_pio_start) w_state_next = StWait;
      StWait: begin
        if (w_pio_grant) begin
          w_starve_next = 8'd0;
          w_state_next  = r_is_rd ? StRd : StAck;
        end else begin
          w_starve_next = r_starve_cnt + 8'd1;
        end
      end
      StRd:   w_state_next = StAck;
      StAck:  if (clk_div) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= StIdle;
      r_starve_cnt    <= 8'd0;
      r_is_rd         <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_mem_rdata     <= '0;
      r_lookup_rvalid <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_starve_cnt    <= w_starve_next;
      r_lookup_rvalid <= w_lookup_acc;
      if ((r_state == StIdle) && w_pio_start) begin
        r_is_rd <= reg_rd;
        r_addr  <= reg_addr[ADDR_NBITS-1:0];
        r_wdata <= reg_din;
      end
      if (r_state == StRd) r_mem_rdata <= ram_rdata[DATA_NBITS-1:0];
    end
  end

`ifdef ENCAP_MEM_PARITY_EN
  logic r_parity_err;

  assign parity_err  = r_parity_err;
  assign lookup_perr = r_lookup_rvalid & (^ram_rdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity_err <= 1'b0;
    end else if (w_pio_go & ~r_is_rd) begin
      r_parity_err <= 1'b0;
    end else if ((r_state == StRd) & (^ram_rdata)) begin
      r_parity_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_encap_mem_pio_arb.sv
// Bench for encap_mem_pio_arb: RAM model, directed timing checks and a
// transaction-timed reference model compared every cycle under random traffic.
module tb_encap_mem_pio_arb;

  localparam int STARVE = 4;
`ifdef ENCAP_MEM_PARITY_EN
  localparam int RAM_W = 33;
`else
  localparam int RAM_W = 32;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clk_div = 1'b0;
  logic              reg_ms = 1'b0, reg_rd = 1'b0, reg_wr = 1'b0;
  logic [31:0]       reg_addr = '0, reg_din = '0;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              lookup_req = 1'b0;
  logic [9:0]        lookup_addr = '0;
  logic              lookup_ready, lookup_rvalid;
  logic [31:0]       lookup_rdata;
  logic              ram_en, ram_wr;
  logic [9:0]        ram_addr;
  logic [RAM_W-1:0]  ram_wdata;
  logic [RAM_W-1:0]  ram_rdata = '0;
`ifdef ENCAP_MEM_PARITY_EN
  logic              lookup_perr, parity_err;
`endif

  encap_mem_pio_arb #(.ADDR_NBITS(10), .DATA_NBITS(32), .STARVE_MAX(STARVE)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_div      (clk_div),
    .reg_ms       (reg_ms),
    .reg_rd       (reg_rd),
    .reg_wr       (reg_wr),
    .reg_addr     (reg_addr),
    .reg_din      (reg_din),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .lookup_req   (lookup_req),
    .lookup_addr  (lookup_addr),
    .lookup_ready (lookup_ready),
    .lookup_rvalid(lookup_rvalid),
    .lookup_rdata (lookup_rdata),
    .ram_en       (ram_en),
    .ram_wr       (ram_wr),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
`ifdef ENCAP_MEM_PARITY_EN
    .ram_rdata    (ram_rdata),
    .lookup_perr  (lookup_perr),
    .parity_err   (parity_err)
`else
    .ram_rdata    (ram_rdata)
`endif
  );

  always #5 clk = ~clk;

  // Single-port RAM, 1-cycle read latency.
  logic [RAM_W-1:0] ram [1024];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one PIO transaction with its request/grant timestamps.
  logic [31:0] shadow [1024];
  bit          mon_en = 1'b0;
  int          mcyc = 0;
  bit          m_op = 0, m_rd = 0, m_granted = 0;
  int          m_start = 0, m_gcyc = 0, m_waits = 0;
  logic [9:0]  m_addr = '0;
  logic [31:0] m_wdata = '0, m_rdata = '0, m_pend = '0, m_prev_data = '0;
  bit          m_pend_v = 0, m_prev_acc = 0;
  int          m_pend_cyc = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      bit in_wait, gcond, go, e_ready, acc, e_ack, idle;
      if (m_pend_v && mcyc >= m_pend_cyc) begin
        m_rdata  = m_pend;
        m_pend_v = 0;
      end
      in_wait = m_op && !m_granted && (mcyc > m_start);
      gcond   = in_wait && (!lookup_req || m_waits == STARVE);
      go      = gcond && !rst;
      e_ready = !gcond;
      acc     = lookup_req && e_ready;
      e_ack   = m_op && m_granted && (mcyc >= m_gcyc + (m_rd ? 2 : 1));

      chk("m_lookup_ready", 32'(lookup_ready), 32'(e_ready));
      chk("m_ram_en", 32'(ram_en), 32'(go || acc));
      chk("m_ram_wr", 32'(ram_wr), 32'(go && !m_rd));
      if (go || acc) chk("m_ram_addr", 32'(ram_addr), 32'(go ? m_addr : lookup_addr));
      if (go && !m_rd) chk("m_ram_wdata", ram_wdata[31:0], m_wdata);
      chk("m_mem_ack", 32'(mem_ack), 32'(e_ack));
      chk("m_mem_rdata", mem_rdata, m_rdata);
      chk("m_lookup_rvalid", 32'(lookup_rvalid), 32'(m_prev_acc));
      if (m_prev_acc) chk("m_lookup_rdata", lookup_rdata, m_prev_data);

      m_prev_acc  = acc && !rst;
      m_prev_data = shadow[lookup_addr];
      if (rst) begin
        m_op = 0; m_rdata = '0; m_pend_v = 0; m_prev_acc = 0;
      end else begin
        idle = !m_op;
        if (go) begin
          m_granted = 1;
          m_gcyc    = mcyc;
          if (m_rd) begin
            m_pend = shadow[m_addr]; m_pend_v = 1; m_pend_cyc = mcyc + 2;
          end else begin
            shadow[m_addr] = m_wdata;
          end
        end else if (in_wait) begin
          m_waits++;
        end
        if (e_ack && clk_div) m_op = 0;
        if (idle && reg_ms && (reg_rd || reg_wr)) begin
          m_op = 1; m_rd = reg_rd; m_addr = reg_addr[9:0]; m_wdata = reg_din;
          m_start = mcyc; m_granted = 0; m_waits = 0;
        end
      end
      mcyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // PIO read with literal latency checks: ack at R+3, clk_div sampled on the first ack cycle.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    tick(); reg_ms = 1; reg_rd = 1; reg_addr = addr;
    tick(); reg_ms = 0; reg_rd = 0; #3;
    chk({tag, "_ram_en"}, 32'(ram_en), 32'd1);
    chk({tag, "_ram_wr"}, 32'(ram_wr), 32'd0);
    tick(); #3;
    chk({tag, "_ack_r2"}, 32'(mem_ack), 32'd0);
    tick(); clk_div = 1; #3;
    chk({tag, "_ack_r3"}, 32'(mem_ack), 32'd1);
    chk({tag, "_rdata"}, mem_rdata, exp);
    tick(); clk_div = 0; #3;
    chk({tag, "_ack_r4"}, 32'(mem_ack), 32'd0);
    chk({tag, "_rdata_hold"}, mem_rdata, exp);
  endtask

  initial begin
    bit [5:0] pat;
    for (int i = 0; i < 1024; i++) begin
      shadow[i] = (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
      ram[i]    = RAM_W'(shadow[i]);
    end

    // Reset
    @(posedge clk); #1; mon_en = 1;
    tick(); rst = 0; #3;
    chk("rst_mem_ack", 32'(mem_ack), 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_rvalid", 32'(lookup_rvalid), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);

    // Idle PIO write
    tick(); reg_ms = 1; reg_wr = 1; reg_addr = 32'h05; reg_din = 32'hDEAD_BEEF; #3;
    chk("wr_ack_r0", 32'(mem_ack), 32'd0);
    tick(); reg_ms = 0; reg_wr = 0; #3;
    chk("wr_ram_wr_r1", 32'(ram_wr), 32'd1);
    chk("wr_ram_addr_r1", 32'(ram_addr), 32'h05);
    chk("wr_ram_wdata_r1", ram_wdata[31:0], 32'hDEAD_BEEF);
    tick(); #3; chk("wr_ack_r2", 32'(mem_ack), 32'd1);
    tick(); #3; chk("wr_ack_r3", 32'(mem_ack), 32'd1);
    tick(); clk_div = 1; #3; chk("wr_ack_r4", 32'(mem_ack), 32'd1);
    tick(); clk_div = 0; #3; chk("wr_ack_r5", 32'(mem_ack), 32'd0);

    do_read(32'h05, 32'hDEAD_BEEF, "rd1");

    // Lookup latency
    tick(); lookup_req = 1; lookup_addr = 10'h05; #3;
    chk("lk_ready", 32'(lookup_ready), 32'd1);
    tick(); lookup_req = 0; #3;
    chk("lk_rvalid", 32'(lookup_rvalid), 32'd1);
    chk("lk_rdata", lookup_rdata, 32'hDEAD_BEEF);

    // Starvation bound: 4 lookups, then PIO grant, then lookups again
    tick(); lookup_req = 1; lookup_addr = 10'h03; reg_ms = 1; reg_rd = 1; reg_addr = 32'h05;
    pat = '0;
    for (int k = 1; k <= 6; k++) begin
      tick(); reg_ms = 0; reg_rd = 0; #3;
      pat = {pat[4:0], lookup_ready};
      if (k == 5) chk("st_pio_addr", 32'(ram_addr), 32'h05);
    end
    chk("st_ready_pattern", 32'(pat), 32'b111101);
    tick(); clk_div = 1; #3;
    chk("st_ack", 32'(mem_ack), 32'd1);
    chk("st_rdata", mem_rdata, 32'hDEAD_BEEF);
    tick(); clk_div = 0; lookup_req = 0;

    // Reset while a write waits behind lookups
    tick(); lookup_req = 1; reg_ms = 1; reg_wr = 1; reg_addr = 32'h05; reg_din = 32'h0BAD_F00D;
    tick(); reg_ms = 0; reg_wr = 0; #3;
    chk("rw_no_wr_r1", 32'(ram_wr), 32'd0);
    tick(); rst = 1; #3;
    chk("rw_no_wr_r2", 32'(ram_wr), 32'd0);
    tick(); rst = 0; lookup_req = 0; #3;
    chk("rw_ack", 32'(mem_ack), 32'd0);
    do_read(32'h05, 32'hDEAD_BEEF, "rd2");

    // Random traffic, moderate then heavy lookup load
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 1500; n++) begin
        tick();
        rst         = ($urandom_range(0, 599) == 0);
        lookup_req  = ($urandom_range(0, 99) < (ph == 0 ? 60 : 95));
        lookup_addr = 10'($urandom_range(0, 15));
        reg_ms      = ($urandom_range(0, 3) == 0);
        reg_rd      = $urandom_range(0, 1) == 1;
        reg_wr      = $urandom_range(0, 1) == 1;
        reg_addr    = $urandom & 32'hFFFF_FC0F;
        reg_din     = $urandom;
        clk_div     = ($urandom_range(0, 3) == 0);
      end
    end
    tick(); rst = 0; lookup_req = 0; reg_ms = 0; reg_rd = 0; reg_wr = 0; clk_div = 0;
    repeat (4) tick();
    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/encap_mem_pio_arb.md
# encap_mem_pio_arb

Per-memory access arbiter between the encap PIO decoder and one encap lookup table (tunnel hash table, tunnel value, ekey hash table or ekey value), one instance per table. It consumes the decoder's module-select plus PIO strobes, and returns `mem_ack`/`mem_rdata` held stable across the slow PIO sampling strobe `clk_div`. It shares one single-port, 1-cycle-latency RAM with the datapath lookup port. Lookups have priority, bounded by a starvation limit.

## Interface
- `ADDR_NBITS`, 10: RAM address width; PIO address bits [ADDR_NBITS-1:0] used.
- `DATA_NBITS`, 32: RAM/PIO data width.
- `STARVE_MAX`, 4: maximum consecutive lookup grants while a PIO op is pending (0..255).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous, active-high.
- `clk_div`  in  1  PIO sampling strobe (one-cycle pulse).
- `reg_ms`  in  1  module select from PIO decoder.
- `reg_rd`  in  1  PIO read strobe.
- `reg_wr`  in  1  PIO write strobe.
- `reg_addr`  in  DATA_NBITS  PIO address.
- `reg_din`  in  DATA_NBITS  PIO write data.
- `mem_ack`  out  1  PIO op complete, held until sampled.
- `mem_rdata`  out  DATA_NBITS  PIO read data, valid while `mem_ack`.
- `lookup_req`  in  1  datapath read request.
- `lookup_addr`  in  ADDR_NBITS  datapath address.
- `lookup_ready`  out  1  lookup accepted this cycle (combinational).
- `lookup_rvalid`  out  1  lookup data valid.
- `lookup_rdata`  out  DATA_NBITS  lookup data.
- `ram_en`, `ram_wr`  out  1  RAM strobes.
- `ram_addr`  out  ADDR_NBITS.
- `ram_wdata`  out  RAM_W  (RAM_W = DATA_NBITS, +1 with parity).
- `ram_rdata`  in  RAM_W  valid 1 cycle after `ram_en & ~ram_wr`.

## Operation
- FSM states: IDLE, WAIT, RD, ACK.
- IDLE: `reg_ms & (reg_rd|reg_wr)` latches op type, address, data → WAIT. Read wins if both strobes set.
- WAIT: `pio_grant = ~lookup_req | (starve_cnt == STARVE_MAX)`.
  - On grant, drive RAM with the PIO op and clear `starve_cnt`. A read goes to RD; a write goes to ACK.
  - Without grant, the lookup is served and `starve_cnt` increments.
- RD: capture `ram_rdata[DATA_NBITS-1:0]` into `mem_rdata` → ACK.
- ACK: `mem_ack=1`. If `clk_div=1` this cycle → IDLE.
- `lookup_ready = ~(state==WAIT & pio_grant)`. When `lookup_req & lookup_ready`, RAM reads `lookup_addr`.
- `lookup_rvalid` is registered from the accept; `lookup_rdata = ram_rdata[DATA_NBITS-1:0]`.
- Lookups are served in every state, including RD and ACK.
- New PIO strobes outside IDLE are ignored. Only one PIO op is outstanding at a time.
- `mem_rdata` holds its last read value and is unchanged by writes.

## Timing
- Reset values: FSM IDLE, `starve_cnt=0`, `mem_ack=0`, `mem_rdata=0`, `lookup_rvalid=0`. RAM strobes are 0 after reset.
- Reset mid-operation aborts any pending PIO op. Nothing is written unless the grant cycle already occurred.
- PIO strobe at cycle R: earliest grant R+1. Read: `mem_ack` rises at R+3. Write: `mem_ack` rises at R+2, and the RAM write occurs at R+1.
- `mem_ack` stays high through the first `clk_div=1` cycle in ACK, inclusive, and falls the next cycle.
  - If `clk_div=1` on the first ACK cycle, `mem_ack` is high for exactly one cycle.
- Lookup latency: accept at T → `lookup_rvalid` at T+1.
- Worst-case PIO grant delay under continuous lookups: STARVE_MAX+1 cycles after entering WAIT.
- `STARVE_MAX=0`: a pending PIO op always wins.

## Configuration
- `ENCAP_MEM_PARITY_EN` defined:
  - RAM_W = DATA_NBITS+1; bit DATA_NBITS stores even parity `^data` on PIO writes.
  - Adds outputs `lookup_perr` (registered with `lookup_rvalid`) and `parity_err`.
  - `parity_err` is sticky: set on a PIO read parity mismatch in RD, cleared by any PIO write grant or reset.
- Not defined: RAM_W = DATA_NBITS, and neither parity output exists.

## Test plan
- Idle PIO write: addr 0x05, din 0xDEADBEEF, no lookups → `ram_wr` at R+1, `mem_ack` rises at R+2. `clk_div` at R+4 → `mem_ack` falls at R+5.
- PIO read back: addr 0x05 → `mem_rdata=0xDEADBEEF` with `mem_ack` at R+3, held until the `clk_div` sample.
- Starvation: STARVE_MAX=4, continuous `lookup_req`, PIO read pending → 4 lookups granted. On the 5th cycle `lookup_ready=0` and PIO is granted; lookups resume the next cycle.
- Lookup latency: `lookup_addr=0x05` accepted at T → `lookup_rvalid=1`, `lookup_rdata=0xDEADBEEF` at T+1.
- Reset in WAIT with a write pending: assert `rst` → no RAM write occurs, `mem_ack=0`, and a later read of the address returns its old value.
- Parity (macro on): force `ram_rdata` bit 32 inverted on a PIO read → `parity_err=1`, held until the next PIO write.
